// File: rtl/spi_ram_master.sv
// SPI master for the SPI-slave/dual-port-RAM wrapper.
// Serialises host RAM commands onto SS_n/MOSI and returns read bytes from MISO.
module spi_ram_master #(
   parameter int TURNAROUND = 2,
   parameter int IDLE_GAP   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      TURN,
      RECV,
      GAP
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [10:0] frame, frame_nxt;
   logic [7:0]  rx_sh, rx_nxt;
   logic        rd, rd_nxt;
   logic        load_rsp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         frame     <= 11'd0;
         rx_sh     <= 8'h00;
         rd        <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         frame     <= frame_nxt;
         rx_sh     <= rx_nxt;
         rd        <= rd_nxt;
         rsp_valid <= load_rsp;
         if (load_rsp)
            rsp_data <= rx_nxt;
      end
   end

   // Counter holds remaining cycles minus one for the current state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      frame_nxt = frame;
      rx_nxt    = rx_sh;
      rd_nxt    = rd;
      load_rsp  = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               frame_nxt = {cmd_type[1], cmd_type,
                            (cmd_type == 2'b11) ? 8'h00 : cmd_data};
               rd_nxt    = (cmd_type == 2'b11);
               cnt_nxt   = 4'd10;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            frame_nxt = {frame[9:0], 1'b0};
            cnt_nxt   = cnt - 4'd1;
            if (cnt == 4'd0) begin
               if (rd) begin
                  state_nxt = TURN;
                  cnt_nxt   = 4'(TURNAROUND - 1);
               end else begin
                  state_nxt = GAP;
                  cnt_nxt   = 4'(IDLE_GAP - 1);
               end
            end
         end
         TURN: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd0) begin
               state_nxt = RECV;
               cnt_nxt   = 4'd7;
            end
         end
         RECV: begin
            rx_nxt  = {rx_sh[6:0], MISO};
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd0) begin
               state_nxt = GAP;
               cnt_nxt   = 4'(IDLE_GAP - 1);
               load_rsp  = 1'b1;
            end
         end
         GAP: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd0)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign SS_n      = !(state == SHIFT || state == TURN || state == RECV);
   assign MOSI      = (state == SHIFT) && frame[10];
   assign busy      = (state != IDLE);
   assign cmd_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: slave/RAM model, frame and response scoreboards.
// A second instance with TURNAROUND=3 checks the longer read latency.
module tb_spi_ram_master;

   localparam int TA  = 2;
   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_type = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
   logic [7:0] rsp_data;

   logic       cmd_valid2 = 1'b0;
   logic [1:0] cmd_type2 = 2'b00;
   logic [7:0] cmd_data2 = 8'h00;
   logic       cmd_ready2, rsp_valid2, busy2, ss_n2, mosi2, miso2;
   logic [7:0] rsp_data2;

   always #5 clk = ~clk;

   spi_ram_master #(.TURNAROUND(TA), .IDLE_GAP(GAP)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
   );

   spi_ram_master #(.TURNAROUND(3), .IDLE_GAP(GAP)) dut3 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_type(cmd_type2), .cmd_data(cmd_data2),
      .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .busy(busy2),
      .SS_n(ss_n2), .MOSI(mosi2), .MISO(miso2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   typedef struct {
      logic [10:0] fr;
      int          len;
   } frm_t;

   frm_t       exp_q[$];
   logic [7:0] rsp_q[$];

   // Slave model: captures frames, runs a small RAM, drives MISO.
   logic [10:0] fsh = '0;
   int          mcnt = 0;
   logic [7:0]  ram [256];
   logic [7:0]  waddr = 8'h00, raddr = 8'h00, rd_byte = 8'h00;
   logic [10:0] word;
   frm_t        ef;

   assign word = {fsh[9:0], mosi};

   always @(negedge clk) begin
      if (rst) begin
         mcnt <= 0;
      end else if (!ss_n) begin
         if (mcnt < 11)
            fsh <= word;
         else
            chk("mosi_quiet", mosi, 0);
         if (mcnt == 10) begin
            unique case (word[9:8])
               2'b00: waddr <= word[7:0];
               2'b01: ram[waddr] <= word[7:0];
               2'b10: raddr <= word[7:0];
               default: rd_byte <= ram[raddr];
            endcase
         end
         mcnt <= mcnt + 1;
      end else if (mcnt != 0) begin
         if (exp_q.size() == 0) begin
            chk("frame_unexpected", mcnt, 0);
         end else begin
            ef = exp_q.pop_front();
            chk("frame_bits", fsh, ef.fr);
            chk("frame_len", mcnt, ef.len);
         end
         mcnt <= 0;
      end
   end

   always_comb begin
      miso = 1'b0;
      if (!ss_n && mcnt >= 12 + TA && mcnt <= 19 + TA)
         miso = rd_byte[7 - (mcnt - 12 - TA)];
   end

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (rsp_q.size() == 0)
            chk("rsp_unexpected", rsp_valid, 0);
         else
            chk("rsp_data", rsp_data, rsp_q.pop_front());
      end
   end

   // Fixed-pattern slave for the TURNAROUND=3 instance.
   int         cnt2 = 0;
   logic [7:0] pat2 = 8'hA5;

   always @(negedge clk) begin
      if (rst || ss_n2)
         cnt2 <= 0;
      else
         cnt2 <= cnt2 + 1;
   end

   always_comb begin
      miso2 = 1'b0;
      if (!ss_n2 && cnt2 >= 15 && cnt2 <= 22)
         miso2 = pat2[7 - (cnt2 - 15)];
   end

   // Called at a negedge; returns right after the accept edge.
   task automatic issue(input logic [1:0] t, input logic [7:0] d,
                        input logic [10:0] fr, input logic [7:0] rsp,
                        input bit track);
      int w;
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_data  = d;
      w = 0;
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100)
         chk("accept_timeout", cmd_ready, 1);
      if (track) begin
         exp_q.push_back('{fr, (t == 2'b11) ? 19 + TA : 11});
         if (t == 2'b11)
            rsp_q.push_back(rsp);
      end
      @(posedge clk);
   endtask

   task automatic window(input logic [1:0] t);
      int len;
      len = (t == 2'b11) ? 19 + TA : 11;
      for (int k = 1; k <= len + 1 + GAP; k++) begin
         @(negedge clk);
         if (k == 1)
            cmd_valid = 1'b0;
         chk("ss_n", ss_n, (k <= len) ? 0 : 1);
         chk("rsp_valid_time", rsp_valid, (t == 2'b11 && k == len + 1) ? 1 : 0);
         chk("cmd_ready_time", cmd_ready, (k >= len + 1 + GAP) ? 1 : 0);
      end
   endtask

   typedef struct {
      logic [1:0]  t;
      logic [7:0]  d;
      logic [10:0] fr;
      logic [7:0]  rsp;
   } vec_t;

   vec_t vt[4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w, gap, k2;

      vt[0] = '{2'b00, 8'h3A, 11'b0_00_00111010, 8'h00};
      vt[1] = '{2'b01, 8'hC5, 11'b0_01_11000101, 8'h00};
      vt[2] = '{2'b10, 8'h3A, 11'b1_10_00111010, 8'h00};
      vt[3] = '{2'b11, 8'h77, 11'b1_11_00000000, 8'hC5};

      repeat (3) @(negedge clk);
      chk("rst_ss_n", ss_n, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ss_n", ss_n, 1);
         chk("idle_mosi", mosi, 0);
         chk("idle_cmd_ready", cmd_ready, 1);
         chk("idle_busy", busy, 0);
      end

      for (int i = 0; i < 4; i++) begin
         issue(vt[i].t, vt[i].d, vt[i].fr, vt[i].rsp, 1'b1);
         window(vt[i].t);
      end

      // Back-to-back with cmd_valid held high.
      issue(2'b00, 8'h01, 11'b0_00_00000001, 8'h00, 1'b1);
      @(negedge clk);
      cmd_type = 2'b01;
      cmd_data = 8'hFF;
      w   = 1;
      gap = 0;
      while (!cmd_ready && w < 40) begin
         @(negedge clk);
         w++;
         if (ss_n && busy)
            gap++;
      end
      chk("b2b_accept_cycle", w, 13);
      chk("b2b_gap", gap, GAP);
      exp_q.push_back('{11'b0_01_11111111, 11});
      @(posedge clk);
      window(2'b01);

      // Reset in cycle 5 of a read-data frame.
      issue(2'b11, 8'h00, 11'b1_11_00000000, 8'h00, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1)
            cmd_valid = 1'b0;
      end
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_ss_n", ss_n, 1);
      chk("abort_rsp_data", rsp_data, 8'h00);
      chk("abort_cmd_ready", cmd_ready, 0);
      chk("abort_busy", busy, 0);
      #1 rst = 1'b0;
      repeat (30) @(negedge clk);
      issue(2'b00, 8'h10, 11'b0_00_00010000, 8'h00, 1'b1);
      window(2'b00);

      // TURNAROUND=3 instance.
      cmd_valid2 = 1'b1;
      cmd_type2  = 2'b11;
      cmd_data2  = 8'h00;
      chk("ta3_ready", cmd_ready2, 1);
      @(posedge clk);
      k2 = 0;
      while (k2 < 40) begin
         @(negedge clk);
         k2++;
         if (k2 == 1)
            cmd_valid2 = 1'b0;
         if (rsp_valid2)
            break;
      end
      chk("ta3_latency", k2, 23);
      chk("ta3_rsp_data", rsp_data2, 8'hA5);
      chk("ta3_ss_n", ss_n2, 1);

      repeat (5) @(negedge clk);
      chk("frames_left", exp_q.size(), 0);
      chk("rsp_left", rsp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
